// File: rtl/ecc_job_scheduler.sv
// Two-requester round-robin scheduler around one serial CRC-8 / Hamming(7,4) engine.
// Optional ECC_JOB_CNT_EN adds a 16-bit accepted-result counter on port job_cnt.
module ecc_job_scheduler #(
   parameter int         STEP = 4,
   parameter logic [8:0] POLY = 9'h18D
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  mode0,
   input  logic [1:0]  mode1,
   input  logic [71:0] data0,
   input  logic [71:0] data1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [71:0] out,
   output logic        out_id,
   output logic        out_err,
`ifdef ECC_JOB_CNT_EN
   output logic [15:0] job_cnt,
`endif
   output logic        busy
);

   localparam logic [6:0] LAST_CYC = 7'(64 / STEP - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXE, S_OUT} state_t;

   state_t      r_state;
   logic        r_prio;
   logic [1:0]  r_mode;
   logic [71:0] r_sh;
   logic [71:0] r_out;
   logic        r_id;
   logic        r_err;
   logic [6:0]  r_cnt;
`ifdef ECC_JOB_CNT_EN
   logic [15:0] r_job_cnt;
`endif

   logic        w_any;
   logic        w_pick;
   logic        w_gnt_ok;
   logic [1:0]  w_mode;
   logic [71:0] w_data;
   logic [6:0]  w_d;
   logic [2:0]  w_syn;
   logic [6:0]  w_fix;
   logic [71:0] w_step;

   // r_prio names the requester that wins a tie; it flips away from each winner.
   assign w_any    = req0 | req1;
   assign w_pick   = (req0 & req1) ? r_prio : req1;
   assign w_gnt_ok = (r_state == S_IDLE) && !rst && w_any;
   assign gnt0     = w_gnt_ok && !w_pick;
   assign gnt1     = w_gnt_ok && w_pick;
   assign w_mode   = w_pick ? mode1 : mode0;
   assign w_data   = w_pick ? data1 : data0;

   assign w_d   = w_data[6:0];
   assign w_syn = {w_d[6] ^ w_d[5] ^ w_d[4] ^ w_d[2],
                   w_d[6] ^ w_d[5] ^ w_d[3] ^ w_d[1],
                   w_d[6] ^ w_d[4] ^ w_d[3] ^ w_d[0]};

   always_comb begin
      w_fix = w_d;
      case (w_syn)
         3'd1:    w_fix[0] = ~w_d[0];
         3'd2:    w_fix[1] = ~w_d[1];
         3'd3:    w_fix[3] = ~w_d[3];
         3'd4:    w_fix[2] = ~w_d[2];
         3'd5:    w_fix[4] = ~w_d[4];
         3'd6:    w_fix[5] = ~w_d[5];
         3'd7:    w_fix[6] = ~w_d[6];
         default: w_fix = w_d;
      endcase
   end

   // Long division with a fixed window at the top; after 64 shifts the remainder sits in [71:64].
   always_comb begin
      w_step = r_sh;
      for (int i = 0; i < STEP; i++) begin
         if (w_step[71])
            w_step[71:63] = w_step[71:63] ^ POLY;
         w_step = {w_step[70:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_prio  <= 1'b0;
         r_mode  <= 2'd0;
         r_sh    <= '0;
         r_out   <= '0;
         r_id    <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
`ifdef ECC_JOB_CNT_EN
         r_job_cnt <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_ok) begin
                  r_id   <= w_pick;
                  r_prio <= ~w_pick;
                  r_mode <= w_mode;
                  r_cnt  <= '0;
                  r_err  <= 1'b0;
                  case (w_mode)
                     2'd0: begin
                        r_sh    <= {w_data[63:0], 8'h00};
                        r_out   <= {w_data[63:0], 8'h00};
                        r_state <= S_EXE;
                     end
                     2'd1: begin
                        r_sh    <= w_data;
                        r_state <= S_EXE;
                     end
                     2'd2: begin
                        r_out   <= {65'b0, w_fix};
                        r_state <= S_OUT;
                     end
                     default: begin
                        r_out   <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_OUT;
                     end
                  endcase
               end
            end
            S_EXE: begin
               r_sh  <= w_step;
               r_cnt <= r_cnt + 7'd1;
               if (r_cnt == LAST_CYC) begin
                  r_state <= S_OUT;
                  if (r_mode == 2'd0)
                     r_out[7:0] <= w_step[71:64];
                  else
                     r_out <= (w_step[71:64] == 8'h00) ? '0 : '1;
               end
            end
            S_OUT: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
                  r_err   <= 1'b0;
`ifdef ECC_JOB_CNT_EN
                  r_job_cnt <= r_job_cnt + 16'd1;
`endif
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign out_valid = (r_state == S_OUT);
   assign busy      = (r_state != S_IDLE);
   assign out       = r_out;
   assign out_id    = r_id;
   assign out_err   = r_err;
`ifdef ECC_JOB_CNT_EN
   assign job_cnt   = r_job_cnt;
`endif

endmodule
